// File: rtl/serial_mag_comp_if.sv
// serial_mag_comp_if: bit-stream inputs and held comparison results of serial_mag_comp
//   start, bit_valid, a_bit, b_bit : master -> comparator (operand bits MSB first)
//   busy, done, altb, agtb, aeqb   : comparator -> master (registered status/result)
interface serial_mag_comp_if;
    logic start, bit_valid, a_bit, b_bit;
    logic busy, done, altb, agtb, aeqb;
    modport master (output start, bit_valid, a_bit, b_bit, input busy, done, altb, agtb, aeqb);
    modport slave (input start, bit_valid, a_bit, b_bit, output busy, done, altb, agtb, aeqb);
endinterface

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial unsigned magnitude comparator, MSB first, WIDTH pairs per result
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_mag_comp_if.slave (start/bit_valid/a_bit/b_bit in; busy/done/altb/agtb/aeqb out)
module serial_mag_comp #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    serial_mag_comp_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic decided_q, decided_d, lt_q, lt_d, gt_q, gt_d;
    logic altb_q, altb_d, agtb_q, agtb_d, aeqb_q, aeqb_d;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            altb_q    <= 1'b0;
            agtb_q    <= 1'b0;
            aeqb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            altb_q    <= altb_d;
            agtb_q    <= agtb_d;
            aeqb_q    <= aeqb_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        altb_d    = altb_q;
        agtb_d    = agtb_q;
        aeqb_d    = aeqb_q;
        if (state_q == SHIFT) begin
            if (bus.bit_valid) begin
                cnt_d = cnt_q + CW'(1);
                // first differing pair (MSB first) settles the outcome; later pairs only count
                if (!decided_q && (bus.a_bit ^ bus.b_bit)) begin
                    decided_d = 1'b1;
                    gt_d      = bus.a_bit;
                    lt_d      = bus.b_bit;
                end
                // the final pair's own decision is folded in via the _d values
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    altb_d  = lt_d;
                    agtb_d  = gt_d;
                    aeqb_d  = !decided_d;
                end
            end
        end else begin
            state_d = (state_q == DONE) ? IDLE : state_q;
            if (bus.start) begin
                state_d   = SHIFT;
                cnt_d     = '0;
                decided_d = 1'b0;
                lt_d      = 1'b0;
                gt_d      = 1'b0;
                altb_d    = 1'b0;
                agtb_d    = 1'b0;
                aeqb_d    = 1'b0;
            end
        end
    end
    assign bus.busy = state_q == SHIFT;
    assign bus.done = state_q == DONE;
    assign bus.altb = altb_q;
    assign bus.agtb = agtb_q;
    assign bus.aeqb = aeqb_q;
endmodule
